// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers used by the program memory and the core.
package cpu_pkg;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSTR_HALT = 32'h0000_0001;
    localparam logic [6:0]  OP_IMM     = 7'b0010011;
    localparam logic [6:0]  OP_REG     = 7'b0110011;

    // Low-address bits that must be zero for a word-aligned access; zero when a word is one byte.
    function automatic logic [31:0] align_mask(input int unsigned word_bytes);
        if (word_bytes > 32'd1) begin
            align_mask = 32'(word_bytes - 32'd1);
        end else begin
            align_mask = 32'h0000_0000;
        end
    endfunction

endpackage

// File: rtl/prog_mem_wordfetch_if.sv
// Load and fetch bus of the program memory: byte-serial loader plus word fetch and load audit status.
interface prog_mem_wordfetch_if #(
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = ADDR_W + 1
);
    logic                         pmWrEn;
    logic [ADDR_W-1:0]            pmAddr;
    logic [BYTE_W-1:0]            instructionIn;
    logic                         fetchEn;
    logic [ADDR_W-1:0]            fetchAddr;
    logic                         fetchValid;
    logic [BYTE_W*WORD_BYTES-1:0] fetchInstr;
    logic                         fetchFault;
    logic [CNT_W-1:0]             byteCount;
    logic [BYTE_W-1:0]            checksum;

    modport master (
        output pmWrEn, pmAddr, instructionIn, fetchEn, fetchAddr,
        input  fetchValid, fetchInstr, fetchFault, byteCount, checksum
    );

    modport slave (
        input  pmWrEn, pmAddr, instructionIn, fetchEn, fetchAddr,
        output fetchValid, fetchInstr, fetchFault, byteCount, checksum
    );
endinterface

// File: rtl/pm_byte_lane_ram.sv
// Byte-wide program RAM with one write port and WORD_BYTES combinational read taps from an aligned base.
module pm_byte_lane_ram #(
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int WORD_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [BYTE_W-1:0]            wr_data,
    input  logic [ADDR_W-1:0]            rd_base,
    output logic [BYTE_W*WORD_BYTES-1:0] rd_word
);
    logic [BYTE_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Byte write; contents survive reset so a program loaded under reset is kept.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_tap
        localparam logic [ADDR_W-1:0] OFF = ADDR_W'(g);
        assign rd_word[g*BYTE_W +: BYTE_W] = mem_r[rd_base + OFF];
    end
endmodule

// File: rtl/prog_mem_wordfetch.sv
// Program memory top: registered word fetch with misalignment fault, write-first bypass and load audit counters.
module prog_mem_wordfetch
    import cpu_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = ADDR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    prog_mem_wordfetch_if.slave bus
);
    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(align_mask(WORD_BYTES));

    logic [ADDR_W-1:0] fetch_base_s;
    logic              misaligned_s;
    logic [WORD_W-1:0] tap_word_s;
    logic [WORD_W-1:0] fetch_word_s;

    logic              fetch_valid_r;
    logic              fetch_fault_r;
    logic [WORD_W-1:0] fetch_instr_r;
    logic              in_session_r;
    logic [CNT_W-1:0]  byte_count_r;
    logic [BYTE_W-1:0] checksum_r;

    assign fetch_base_s = bus.fetchAddr & ~LANE_MASK;
    assign misaligned_s = |(bus.fetchAddr & LANE_MASK);

    pm_byte_lane_ram #(
        .BYTE_W    (BYTE_W),
        .ADDR_W    (ADDR_W),
        .WORD_BYTES(WORD_BYTES)
    ) u_ram (
        .clk    (clk),
        .wr_en  (bus.pmWrEn),
        .wr_addr(bus.pmAddr),
        .wr_data(bus.instructionIn),
        .rd_base(fetch_base_s),
        .rd_word(tap_word_s)
    );

    // Write-first bypass: a byte landing in the fetched word this cycle replaces its lane.
    always_comb begin
        fetch_word_s = tap_word_s;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (bus.pmWrEn && (bus.pmAddr == (fetch_base_s + ADDR_W'(i)))) begin
                fetch_word_s[i*BYTE_W +: BYTE_W] = bus.instructionIn;
            end else begin
                fetch_word_s[i*BYTE_W +: BYTE_W] = tap_word_s[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Fetch pipeline register; a misaligned request returns an all-zero word (NOP).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
            fetch_instr_r <= '0;
        end else if (bus.fetchEn) begin
            fetch_valid_r <= 1'b1;
            if (misaligned_s) begin
                fetch_fault_r <= 1'b1;
                fetch_instr_r <= '0;
            end else begin
                fetch_fault_r <= 1'b0;
                fetch_instr_r <= fetch_word_s;
            end
        end else begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
        end
    end

    // Load-session audit: restarts on the first write after an idle cycle, runs regardless of rst.
    always_ff @(posedge clk) begin
        in_session_r <= bus.pmWrEn;
        if (bus.pmWrEn) begin
            if (!in_session_r) begin
                byte_count_r <= {{(CNT_W-1){1'b0}}, 1'b1};
                checksum_r   <= bus.instructionIn;
            end else begin
                if (byte_count_r != {CNT_W{1'b1}}) begin
                    byte_count_r <= byte_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                checksum_r <= checksum_r + bus.instructionIn;
            end
        end
    end

    assign bus.fetchValid = fetch_valid_r;
    assign bus.fetchFault = fetch_fault_r;
    assign bus.fetchInstr = fetch_instr_r;
    assign bus.byteCount  = byte_count_r;
    assign bus.checksum   = checksum_r;
endmodule

// File: tb/tb_prog_mem_wordfetch.sv
// Self-checking bench for prog_mem_wordfetch: directed scenarios then randomized traffic against a byte-array model.
module tb_prog_mem_wordfetch;
    localparam int BW = 8;
    localparam int AW = 7;
    localparam int WB = 4;
    localparam int CW = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    prog_mem_wordfetch_if #(.BYTE_W(BW), .ADDR_W(AW), .WORD_BYTES(WB), .CNT_W(CW)) bus ();

    prog_mem_wordfetch #(.BYTE_W(BW), .ADDR_W(AW), .WORD_BYTES(WB), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [7:0]  ref_mem [DEPTH];
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] exp_instr;
    int          m_cnt;
    logic [7:0]  m_sum;
    logic        prev_wr;
    logic        seen_session;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int a);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < WB; i++) begin
            w[8*i +: 8] = ref_mem[(a + i) % DEPTH];
        end
        return w;
    endfunction

    // One clock: drive inputs, update the model at the edge, compare just after it.
    task automatic step(input logic r, input logic wr, input logic [6:0] wa, input logic [7:0] wd,
                        input logic fe, input logic [6:0] fa);
        rst               = r;
        bus.pmWrEn        = wr;
        bus.pmAddr        = wa;
        bus.instructionIn = wd;
        bus.fetchEn       = fe;
        bus.fetchAddr     = fa;
        @(posedge clk);
        if (wr) begin
            ref_mem[int'(wa)] = wd;
            if (!prev_wr) begin
                m_cnt = 1;
                m_sum = wd;
            end else begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                m_sum = m_sum + wd;
            end
            seen_session = 1'b1;
        end
        prev_wr = wr;
        if (r) begin
            exp_valid = 1'b0;
            exp_fault = 1'b0;
            exp_instr = 32'h0;
        end else if (fe) begin
            exp_valid = 1'b1;
            if ((int'(fa) % WB) != 0) begin
                exp_fault = 1'b1;
                exp_instr = 32'h0;
            end else begin
                exp_fault = 1'b0;
                exp_instr = word_at(int'(fa));
            end
        end else begin
            exp_valid = 1'b0;
            exp_fault = 1'b0;
        end
        #1;
        check("fetchValid", 64'(bus.fetchValid), 64'(exp_valid));
        check("fetchFault", 64'(bus.fetchFault), 64'(exp_fault));
        check("fetchInstr", 64'(bus.fetchInstr), 64'(exp_instr));
        if (seen_session) begin
            check("byteCount", 64'(bus.byteCount), 64'(m_cnt));
            check("checksum", 64'(bus.checksum), 64'(m_sum));
        end
    endtask

    initial begin
        logic [7:0] load_bytes [4];
        logic [7:0] r_data;
        logic [6:0] r_addr;
        logic       r_wr;
        logic       r_fe;
        logic       r_rst;
        tests = 0;
        fails = 0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_instr = 32'h0;
        m_cnt = 0;
        m_sum = 8'h00;
        prev_wr = 1'b0;
        seen_session = 1'b0;
        rst = 1'b1;
        bus.pmWrEn = 1'b0;
        bus.pmAddr = 7'h00;
        bus.instructionIn = 8'h00;
        bus.fetchEn = 1'b0;
        bus.fetchAddr = 7'h00;

        // reset state, fetch requested under reset is dropped
        step(1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00);
        step(1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 7'h00);
        check("reset_valid", 64'(bus.fetchValid), 64'h0);
        check("reset_instr", 64'(bus.fetchInstr), 64'h0);

        // fill the whole memory under reset so every later fetch has defined contents
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b1, 7'(a), 8'($urandom), 1'b0, 7'h00);
        end
        check("fill_count", 64'(bus.byteCount), 64'd128);
        step(1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00);

        // load under reset: 93 00 30 00 at 0..3
        load_bytes[0] = 8'h93; load_bytes[1] = 8'h00; load_bytes[2] = 8'h30; load_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 7'(i), load_bytes[i], 1'b0, 7'h00);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h00);
        check("load_word", 64'(bus.fetchInstr), 64'h0030_0093);
        check("load_count", 64'(bus.byteCount), 64'd4);
        check("load_sum", 64'(bus.checksum), 64'hC3);

        // second session at 40..43
        load_bytes[0] = 8'h01; load_bytes[1] = 8'h00; load_bytes[2] = 8'h00; load_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(40 + i), load_bytes[i], 1'b0, 7'h00);
        check("sess2_count", 64'(bus.byteCount), 64'd4);
        check("sess2_sum", 64'(bus.checksum), 64'h01);

        // misaligned then aligned
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h02);
        check("misalign_fault", 64'(bus.fetchFault), 64'h1);
        check("misalign_instr", 64'(bus.fetchInstr), 64'h0);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h04);
        check("aligned_fault", 64'(bus.fetchFault), 64'h0);

        // bypass: word 0x0C = 0021_00B3, then write FF to 0x0D while fetching 0x0C
        load_bytes[0] = 8'hB3; load_bytes[1] = 8'h00; load_bytes[2] = 8'h21; load_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(12 + i), load_bytes[i], 1'b0, 7'h00);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00);
        step(1'b0, 1'b1, 7'h0D, 8'hFF, 1'b1, 7'h0C);
        check("bypass_word", 64'(bus.fetchInstr), 64'h0021_FFB3);

        // top of memory, then reset pulse in the middle of a valid result
        load_bytes[0] = 8'hAA; load_bytes[1] = 8'hBB; load_bytes[2] = 8'hCC; load_bytes[3] = 8'hDD;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(124 + i), load_bytes[i], 1'b0, 7'h00);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h7C);
        check("wrap_word", 64'(bus.fetchInstr), 64'hDDCC_BBAA);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.fetchValid), 64'h0);
        check("midrst_instr", 64'(bus.fetchInstr), 64'h0);
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_instr = 32'h0;
        rst = 1'b0;
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h7C);
        check("refetch_word", 64'(bus.fetchInstr), 64'hDDCC_BBAA);

        // back-to-back fetches, then idle holds the last word
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h00);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h04);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 7'h08);
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00);
        check("idle_valid", 64'(bus.fetchValid), 64'h0);
        check("idle_hold", 64'(bus.fetchInstr), 64'(word_at(8)));

        // randomized traffic, including bypass collisions and occasional reset
        for (int n = 0; n < 400; n++) begin
            r_rst  = ($urandom_range(0, 24) == 0);
            r_wr   = 1'($urandom);
            r_fe   = ($urandom_range(0, 3) != 0);
            r_data = 8'($urandom);
            r_addr = 7'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                step(r_rst, r_wr, r_addr, r_data, r_fe, (r_addr & 7'h7C));
            end else begin
                step(r_rst, r_wr, r_addr, r_data, r_fe, 7'($urandom));
            end
        end

        // one long session: byteCount saturates at all-ones
        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00);
        for (int n = 0; n < 264; n++) begin
            step(1'b0, 1'b1, 7'($urandom), 8'($urandom), 1'($urandom), 7'($urandom) & 7'h7C);
        end
        check("sat_count", 64'(bus.byteCount), 64'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
